ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
- Instruction-fetch controller directly upstream of the PC register.
- Reads the current PC (pcreg data_out) and issues a held-request read to instruction memory.
- Produces the next PC and its write-enable (pcreg data_in/ena).
- Hands each fetched word plus its PC to decode through a one-entry valid/ready output register. Supports redirect (branch/jump) with safe discard of an in-flight fetch.

Parameters:
- PC_STEP, 4, sequential PC increment in bytes.
- ALIGN_BITS, 2, low PC bits forced to zero on redirect targets.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_in  in  32  current PC from PC register output.
- pc_next  out  32  next PC to PC register data input.
- pc_ena  out  1  PC register write enable; PC updates at the edge where pc_ena=1.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  registered fetch address; stable while imem_req=1.
- imem_ack  in  1  one-cycle response strobe; imem_rdata valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- redirect  in  1  one-cycle flush/jump request.
- redirect_pc  in  32  jump target.
- inst_valid  out  1  output register holds an instruction.
- inst  out  32  fetched instruction.
- inst_pc  out  32  PC of inst.
- inst_ready  in  1  decode accepts; pop when inst_valid&&inst_ready.

Behaviour:
- Reset (rst=0, asynchronous): state=S_IDLE; imem_req=0; imem_addr=0; inst_valid=0; inst=0; inst_pc=0.
- During reset pc_ena=0 and pc_next=pc_in (pc_ena, pc_next are combinational).
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP.
- S_IDLE: one cycle after reset release, then S_REQ.
- S_REQ (issue):
  - If the buffer is empty or popping this cycle: set imem_req=1 and imem_addr=pc_in at the edge, go S_WAIT.
  - Otherwise go S_HOLD.
- S_WAIT:
  - imem_req=1 and imem_addr held.
  - On imem_ack: load inst=imem_rdata, inst_pc=imem_addr, inst_valid=1; drop imem_req. Same cycle: pc_ena=1, pc_next=pc_in+PC_STEP. Then go S_REQ.
- S_HOLD: wait until the pop, then go S_REQ. No request is outstanding.
- Buffer capacity: a request is issued only when the buffer is empty at the following edge, so an ack never finds the buffer full. No overflow path exists.
- Pop without refill: inst_valid clears at the edge.
- Redirect (any non-reset state) takes priority over everything else:
  - pc_ena=1, pc_next={redirect_pc[31:ALIGN_BITS], ALIGN_BITS'b0}.
  - inst_valid clears at the edge, even if inst_ready=1 that cycle; decode must not consume that word.
- Redirect in S_WAIT without ack: imem_req stays high with the old imem_addr; go S_DROP. In S_DROP the ack data is discarded with no buffer write and pc_ena=0; then go S_REQ.
- Redirect in S_WAIT coincident with ack: ack data discarded; transaction is complete; go S_REQ.
- Redirect in S_DROP: the new target overwrites the PC; remain in S_DROP.
- Redirect in S_IDLE, S_REQ or S_HOLD: go S_REQ.
- PC arithmetic: modulo 2^32. pc_in=32'hFFFF_FFFC gives pc_next=32'h0000_0000. No misalignment check on pc_in.
- Throughput: minimum 2 cycles per instruction (issue, ack) with zero-wait memory and decode always ready.
- Reset asserted mid-transaction: everything is cleared immediately; a late imem_ack is ignored because it arrives in S_IDLE.

Test Plan:
- Reset, then pc_in=0; memory acks 1 cycle after req with rdata 32'h2008_0001; inst_ready=1 → imem_addr=0; inst=32'h2008_0001, inst_pc=0; pc_ena pulse with pc_next=4; next imem_addr=4.
- inst_ready=0 after first fetch → FSM parks in S_HOLD, imem_req=0, inst held. Raise inst_ready → next request issued with imem_addr=4.
- Redirect to 32'h0000_1003 while req pending (ack 3 cycles later, rdata 32'hDEAD_BEEF) → pc_next=32'h0000_1000; DEADBEEF never appears as inst_valid; next imem_addr=32'h0000_1000.
- Redirect in the same cycle as ack → data dropped, inst_valid=0, pc_next=redirect target.
- pc_in=32'hFFFF_FFFC, ack → pc_next=0, inst_pc=32'hFFFF_FFFC.
- rst=0 asserted mid-S_WAIT, ack arrives during reset → all outputs 0, no inst_valid; fetch resumes cleanly 2 cycles after release.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: drives the PC register, issues held-request reads to
// instruction memory and presents fetched words to decode through a one-entry output register.
module ifetch_ctrl #(
  parameter int unsigned PC_STEP    = 4,
  parameter int unsigned ALIGN_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_next,
  output logic        pc_ena,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state, state_nxt;
  logic        req_nxt;
  logic [31:0] addr_nxt;
  logic        vld_nxt;
  logic        load_buf;
  logic        pop;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~((32'd1 << ALIGN_BITS) - 32'd1);
  endfunction

  assign pop = inst_valid && inst_ready;

  always_comb begin
    state_nxt = state;
    req_nxt   = imem_req;
    addr_nxt  = imem_addr;
    vld_nxt   = inst_valid;
    load_buf  = 1'b0;
    pc_ena    = 1'b0;
    pc_next   = pc_in;
    if (pop) vld_nxt = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        // Issue only when the buffer will be empty, so an ack always has room.
        if (!redirect) begin
          if (!inst_valid || pop) begin
            req_nxt   = 1'b1;
            addr_nxt  = pc_in;
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_HOLD;
          end
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          req_nxt   = 1'b0;
          state_nxt = S_REQ;
          if (!redirect) begin
            load_buf = 1'b1;
            vld_nxt  = 1'b1;
            pc_ena   = 1'b1;
            pc_next  = pc_in + 32'(PC_STEP);
          end
        end else if (redirect) begin
          state_nxt = S_DROP;
        end
      end
      S_HOLD: if (redirect || pop) state_nxt = S_REQ;
      S_DROP: begin
        // Stale fetch still owed by memory: retire it without touching the buffer.
        if (imem_ack) begin
          req_nxt   = 1'b0;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (redirect) begin
      pc_ena  = 1'b1;
      pc_next = align_pc(redirect_pc);
      vld_nxt = 1'b0;
    end
    if (!rst) begin
      pc_ena  = 1'b0;
      pc_next = pc_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      imem_req   <= 1'b0;
      imem_addr  <= 32'd0;
      inst_valid <= 1'b0;
      inst       <= 32'd0;
      inst_pc    <= 32'd0;
    end else begin
      state      <= state_nxt;
      imem_req   <= req_nxt;
      imem_addr  <= addr_nxt;
      inst_valid <= vld_nxt;
      if (load_buf) begin
        inst    <= imem_rdata;
        inst_pc <= imem_addr;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: a bench-side PC register follows pc_ena/pc_next,
// memory acks and decode readiness are driven cycle by cycle from scenario tasks.
module tb_ifetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] pc_next;
  logic        pc_ena;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        pc_load;
  logic [31:0] pc_load_val;
  int          checks = 0;
  int          errors = 0;

  ifetch_ctrl dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_next(pc_next), .pc_ena(pc_ena),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  // PC register model; pc_load lets a scenario plant an arbitrary PC.
  always @(posedge clk) begin
    if (pc_load) pc_in <= pc_load_val;
    else if (pc_ena) pc_in <= pc_next;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; redirect = 1'b0; redirect_pc = 32'd0;
    inst_ready = 1'b1; pc_load = 1'b1; pc_load_val = 32'd0;
    tick; tick;
    redirect = 1'b1; redirect_pc = 32'h0000_1234;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%0h exp=0", imem_req); end
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", inst_valid); end
    checks++; if (inst !== 32'd0) begin errors++; $display("FAIL rst_inst got=%h exp=0", inst); end
    checks++; if (inst_pc !== 32'd0) begin errors++; $display("FAIL rst_inst_pc got=%h exp=0", inst_pc); end
    checks++; if (pc_ena !== 1'b0) begin errors++; $display("FAIL rst_pc_ena got=%0h exp=0", pc_ena); end
    checks++; if (pc_next !== 32'd0) begin errors++; $display("FAIL rst_pc_next got=%h exp=0", pc_next); end
    redirect = 1'b0; pc_load = 1'b0;
  endtask

  task automatic test_basic_fetch;
    rst = 1'b1;
    tick;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got=%0h exp=0", imem_req); end
    tick;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got=%0h exp=1", imem_req); end
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL first_addr got=%h exp=0", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h2008_0001;
    #1;
    checks++; if (pc_ena !== 1'b1) begin errors++; $display("FAIL ack_pc_ena got=%0h exp=1", pc_ena); end
    checks++; if (pc_next !== 32'd4) begin errors++; $display("FAIL ack_pc_next got=%h exp=4", pc_next); end
    tick;
    imem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%0h exp=1", inst_valid); end
    checks++; if (inst !== 32'h2008_0001) begin errors++; $display("FAIL first_inst got=%h exp=20080001", inst); end
    checks++; if (inst_pc !== 32'd0) begin errors++; $display("FAIL first_inst_pc got=%h exp=0", inst_pc); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ack_drop_req got=%0h exp=0", imem_req); end
    tick;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL second_req got=%0h exp=1", imem_req); end
    checks++; if (imem_addr !== 32'd4) begin errors++; $display("FAIL second_addr got=%h exp=4", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL pop_clear got=%0h exp=0", inst_valid); end
  endtask

  task automatic test_hold;
    inst_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1111_0001;
    tick;
    imem_ack = 1'b0;
    tick;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req got=%0h exp=0", imem_req); end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got=%0h exp=1", inst_valid); end
    checks++; if (inst !== 32'h1111_0001) begin errors++; $display("FAIL hold_inst got=%h exp=11110001", inst); end
    checks++; if (inst_pc !== 32'd4) begin errors++; $display("FAIL hold_inst_pc got=%h exp=4", inst_pc); end
    tick;
    checks++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL hold_stay got=%0h/%0h exp=1/0", inst_valid, imem_req); end
    inst_ready = 1'b1;
    tick;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL hold_pop got=%0h/%0h exp=0/0", inst_valid, imem_req); end
    tick;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL after_hold_req got=%0h exp=1", imem_req); end
    checks++; if (imem_addr !== 32'd8) begin errors++; $display("FAIL after_hold_addr got=%h exp=8", imem_addr); end
  endtask

  task automatic test_redirect_pending;
    redirect = 1'b1; redirect_pc = 32'h0000_1003;
    #1;
    checks++; if (pc_ena !== 1'b1) begin errors++; $display("FAIL rdp_pc_ena got=%0h exp=1", pc_ena); end
    checks++; if (pc_next !== 32'h0000_1000) begin errors++; $display("FAIL rdp_pc_next got=%h exp=00001000", pc_next); end
    tick;
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rdp_req_held got=%0h exp=1", imem_req); end
    checks++; if (imem_addr !== 32'd8) begin errors++; $display("FAIL rdp_addr_held got=%h exp=8", imem_addr); end
    tick;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (pc_ena !== 1'b0) begin errors++; $display("FAIL drop_pc_ena got=%0h exp=0", pc_ena); end
    tick;
    imem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL drop_valid got=%0h exp=0 inst=%h", inst_valid, inst); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drop_req got=%0h exp=0", imem_req); end
    tick;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_1000) begin errors++; $display("FAIL rdp_new_addr got=%0h/%h exp=1/00001000", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_ack;
    imem_ack = 1'b1; imem_rdata = 32'h3333_0003; redirect = 1'b1; redirect_pc = 32'h0000_2000;
    #1;
    checks++; if (pc_ena !== 1'b1 || pc_next !== 32'h0000_2000) begin errors++; $display("FAIL rda_pc got=%0h/%h exp=1/00002000", pc_ena, pc_next); end
    tick;
    imem_ack = 1'b0; redirect = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rda_valid got=%0h exp=0", inst_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rda_req got=%0h exp=0", imem_req); end
    tick;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_2000) begin errors++; $display("FAIL rda_new_addr got=%0h/%h exp=1/00002000", imem_req, imem_addr); end
  endtask

  task automatic test_wrap;
    imem_ack = 1'b1; imem_rdata = 32'h4444_0004; pc_load = 1'b1; pc_load_val = 32'hFFFF_FFFC;
    #1;
    checks++; if (pc_next !== 32'h0000_2004) begin errors++; $display("FAIL seq_pc_next got=%h exp=00002004", pc_next); end
    tick;
    imem_ack = 1'b0; pc_load = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_2000) begin errors++; $display("FAIL seq_inst got=%0h/%h exp=1/00002000", inst_valid, inst_pc); end
    tick;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h5555_0005;
    #1;
    checks++; if (pc_ena !== 1'b1 || pc_next !== 32'd0) begin errors++; $display("FAIL wrap_pc_next got=%0h/%h exp=1/0", pc_ena, pc_next); end
    tick;
    imem_ack = 1'b0;
    checks++; if (inst !== 32'h5555_0005 || inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_inst got=%h/%h exp=55550005/fffffffc", inst, inst_pc); end
  endtask

  task automatic test_redirect_flush;
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3002;
    #1;
    checks++; if (pc_next !== 32'h0000_3000) begin errors++; $display("FAIL flush_pc_next got=%h exp=00003000", pc_next); end
    tick;
    redirect = 1'b0;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL flush_clear got=%0h/%0h exp=0/0", inst_valid, imem_req); end
    tick;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin errors++; $display("FAIL flush_addr got=%0h/%h exp=1/00003000", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid;
    #1;
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'd0) begin errors++; $display("FAIL mid_rst_req got=%0h/%h exp=0/0", imem_req, imem_addr); end
    checks++; if (inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== 32'd0) begin errors++; $display("FAIL mid_rst_buf got=%0h/%h/%h exp=0/0/0", inst_valid, inst, inst_pc); end
    imem_ack = 1'b1; imem_rdata = 32'h6666_0006;
    #1;
    checks++; if (pc_ena !== 1'b0) begin errors++; $display("FAIL mid_rst_pc_ena got=%0h exp=0", pc_ena); end
    tick;
    imem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b0 || inst !== 32'd0) begin errors++; $display("FAIL late_ack got=%0h/%h exp=0/0", inst_valid, inst); end
    rst = 1'b1;
    tick;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL resume_idle got=%0h exp=0", imem_req); end
    tick;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin errors++; $display("FAIL resume_addr got=%0h/%h exp=1/00003000", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h7777_0007;
    #1;
    checks++; if (pc_next !== 32'h0000_3004) begin errors++; $display("FAIL resume_pc_next got=%h exp=00003004", pc_next); end
    tick;
    imem_ack = 1'b0;
    checks++; if (inst !== 32'h7777_0007 || inst_pc !== 32'h0000_3000) begin errors++; $display("FAIL resume_inst got=%h/%h exp=77770007/00003000", inst, inst_pc); end
  endtask

  initial begin
    test_reset;
    test_basic_fetch;
    test_hold;
    test_redirect_pending;
    test_redirect_ack;
    test_wrap;
    test_redirect_flush;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
